score_tracker: RTL and testbench
================================

# score_tracker

Parametrised score and high-score tracker for the Flappy Bird game datapath. It watches the right-edge X position of `NUM_PIPES` obstacle channels and adds exactly one point per pipe each time that pipe's right edge passes the bird's X position. It runs a small game-phase FSM (IDLE/PLAYING/OVER) and keeps a high score across rounds. It sits between the obstacle movers and the score display/HUD logic.

## Interface
- `NUM_PIPES`, 3, number of obstacle channels (1..8)
- `POS_W`, 10, width of obstacle X positions
- `SCORE_W`, 10, width of score and high score
- `BIRD_X`, `BIRD_STARTING_DISTANCE` (package), bird X; a pipe has passed when its right edge is < `BIRD_X`

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse: begin a new round
- `game_over`  in  1  single-cycle pulse: bird collided
- `obs_valid`  in  `NUM_PIPES`  per-channel: pipe is on screen
- `obs_right`  in  `NUM_PIPES`×`POS_W`  packed right-edge X per channel; channel i = bits [i*POS_W +: POS_W]
- `score`  out  `SCORE_W`  current round score
- `high_score`  out  `SCORE_W`  best score since reset
- `new_high`  out  1  level: last finished round set a new high score
- `score_inc`  out  1  pulse: `score` changed this cycle
- `playing`  out  1  FSM is in PLAYING

## Operation
- FSM states: IDLE (reset state), PLAYING, OVER.
  - IDLE/OVER, `start`=1 -> PLAYING. `score` clears to 0, `new_high` clears, and every channel's armed flag loads `obs_valid[i] && obs_right[i] >= BIRD_X`.
  - PLAYING, `game_over`=1 -> OVER. If `score > high_score` then `high_score <= score` and `new_high <= 1`.
  - PLAYING, `start`=1 is ignored. OVER/IDLE, `game_over`=1 is ignored.
- Per-channel armed flag:
  - A crossing on channel i occurs when `armed[i] && obs_valid[i] && obs_right[i] < BIRD_X`. The flag then clears.
  - The flag re-arms when `obs_valid[i] && obs_right[i] >= BIRD_X`, i.e. the pipe respawns on the right.
  - A channel that is invalid holds its flag.
  - Each pipe pass therefore scores once, no matter how long the pipe sits left of the bird.
- Scoring happens in PLAYING only: `score <= score + popcount(crossings)`.
  - Several channels crossing in the same cycle all count.
  - The sum saturates at 2^SCORE_W−1; there is no wrap.
  - `score_inc` is 1 in the cycle after a nonzero increment that actually changed `score`. It is 0 at saturation.
- `game_over` has priority: crossings in the same cycle as `game_over` are not counted, but armed flags still update.
- Reset (any time, including mid-round): state=IDLE, `score`=0, `high_score`=0, `new_high`=0, `score_inc`=0, `playing`=0, all armed flags=0.

## Timing
- All outputs are registered.
- `score` reflects a crossing sampled at edge n at edge n+1, i.e. a latency of 1 cycle.
- `playing` rises 1 cycle after `start` and falls 1 cycle after `game_over`.
- `high_score` and `new_high` update on the same edge on which the FSM enters OVER.
- Inputs are sampled every cycle. There is no handshake; `start` and `game_over` are expected as pulses, but a held level is safe because each transition fires once.

## Structure
- Shared game package provides `BIRD_STARTING_DISTANCE`, `SCREEN_W`, and a `game_phase_t` enum (IDLE, PLAYING, OVER). The FSM state uses `game_phase_t`.
- Sub-module `pipe_pass_detector` (one instance per channel, via generate): inputs `clk`, `reset`, `load`, `valid`, `right`; outputs `crossing` and `armed`.
- The top level holds the FSM, popcount, saturating adder and high-score register.

## Test plan
- Single pass, NUM_PIPES=3, BIRD_X=160:
  - `start`, then ch0 ramps 200→150 and holds at 150 for 20 cycles -> `score`=1, one `score_inc` pulse.
  - ch0 jumps to 639 and ramps down past 160 again -> `score`=2.
- Simultaneous crossings: ch0, ch1 and ch2 all go 161→159 on the same edge -> `score` +3 in one cycle, one `score_inc` pulse.
- Saturation, SCORE_W=4: 16 single passes -> `score` sticks at 15, and `score_inc` is 0 on the 16th pass.
- High score over rounds:
  - Round 1 scores 5, then `game_over` -> `high_score`=5, `new_high`=1.
  - Round 2 scores 3 -> `high_score` stays 5, `new_high`=0.
  - Round 3 scores 7 -> `high_score`=7.
- Edge cases:
  - `game_over` on the same edge as a crossing -> `score` is unchanged.
  - Pipe already left of the bird at `start` -> no point.
  - `obs_valid`=0 during a crossing -> no point.
- Async reset mid-round at `score`=4, `high_score`=9, asserted between clock edges -> all outputs read 0 immediately, the FSM is in IDLE, and crossings are ignored until `start`.

Source files
------------

// File: rtl/score_tracker_pkg.sv
// score_tracker_pkg: shared game constants, phase enum and popcount helper.
package score_tracker_pkg;

    localparam int SCREEN_W               = 640;
    localparam int BIRD_STARTING_DISTANCE = 160;

    typedef enum logic [1:0] {IDLE, PLAYING, OVER} game_phase_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        popcount8 = '0;
        for (int i = 0; i < 8; i++) popcount8 = popcount8 + 4'(v[i]);
    endfunction

endpackage

// File: rtl/score_tracker_if.sv
// score_tracker_if: game control, obstacle channels and score outputs.
interface score_tracker_if #(
    parameter int NUM_PIPES = 3,
    parameter int POS_W     = 10,
    parameter int SCORE_W   = 10
);
    logic                       start;
    logic                       game_over;
    logic [NUM_PIPES-1:0]       obs_valid;
    logic [NUM_PIPES*POS_W-1:0] obs_right;
    logic [SCORE_W-1:0]         score;
    logic [SCORE_W-1:0]         high_score;
    logic                       new_high;
    logic                       score_inc;
    logic                       playing;

    modport master (
        output start, game_over, obs_valid, obs_right,
        input  score, high_score, new_high, score_inc, playing
    );

    modport slave (
        input  start, game_over, obs_valid, obs_right,
        output score, high_score, new_high, score_inc, playing
    );
endinterface

// File: rtl/score_tracker_pipe_pass_detector.sv
// pipe_pass_detector: flags one crossing per pipe pass; re-arms when the pipe is back on the bird's right.
module pipe_pass_detector #(
    parameter int POS_W  = 10,
    parameter int BIRD_X = 160
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             valid,
    input  logic [POS_W-1:0] right,
    output logic             crossing,
    output logic             armed
);
    localparam logic [POS_W-1:0] BX = POS_W'(BIRD_X);

    logic armed_q, armed_d, ahead;

    always_comb begin
        ahead    = valid && right >= BX;
        crossing = armed_q && valid && right < BX;
        // an invalid channel keeps its flag unless a new round reloads it
        armed_d  = (valid || load) ? ahead : armed_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) armed_q <= 1'b0;
        else        armed_q <= armed_d;
    end

    assign armed = armed_q;

endmodule

// File: rtl/score_tracker.sv
// score_tracker: round FSM, per-pipe pass scoring with saturation, and high-score tracking.
module score_tracker
    import score_tracker_pkg::*;
#(
    parameter int NUM_PIPES = 3,
    parameter int POS_W     = 10,
    parameter int SCORE_W   = 10,
    parameter int BIRD_X    = BIRD_STARTING_DISTANCE
) (
    input logic            clk,
    input logic            reset,
    score_tracker_if.slave bus
);
    localparam int SUM_W = SCORE_W + 4;
    localparam logic [SUM_W-1:0] MAX = SUM_W'({SCORE_W{1'b1}});

    game_phase_t          state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d, high_q, high_d, sat;
    logic                 new_high_q, new_high_d, score_inc_q, score_inc_d;
    logic                 playing_q, playing_d, load;
    logic [NUM_PIPES-1:0] crossing, armed;
    logic [7:0]           cross8;
    logic [SUM_W-1:0]     sum;
    logic                 unused_armed;

    assign load = bus.start && state_q != PLAYING;

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_det
        pipe_pass_detector #(.POS_W(POS_W), .BIRD_X(BIRD_X)) u_det (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .valid    (bus.obs_valid[g]),
            .right    (bus.obs_right[g*POS_W +: POS_W]),
            .crossing (crossing[g]),
            .armed    (armed[g])
        );
    end

    assign unused_armed = ^armed;

    always_comb begin
        cross8                  = '0;
        cross8[NUM_PIPES-1:0]   = crossing;
        sum                     = SUM_W'(score_q) + SUM_W'(popcount8(cross8));
        sat                     = sum > MAX ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
        state_d                 = state_q;
        score_d                 = score_q;
        high_d                  = high_q;
        new_high_d              = new_high_q;
        score_inc_d             = 1'b0;
        if (load) begin
            state_d    = PLAYING;
            score_d    = '0;
            new_high_d = 1'b0;
        end else if (state_q == PLAYING && bus.game_over) begin
            state_d    = OVER;
            high_d     = score_q > high_q ? score_q : high_q;
            new_high_d = score_q > high_q;
        end else if (state_q == PLAYING) begin
            score_d     = sat;
            score_inc_d = sat != score_q;
        end
        playing_d = state_d == PLAYING;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            score_q     <= '0;
            high_q      <= '0;
            new_high_q  <= 1'b0;
            score_inc_q <= 1'b0;
            playing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            high_q      <= high_d;
            new_high_q  <= new_high_d;
            score_inc_q <= score_inc_d;
            playing_q   <= playing_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.high_score = high_q;
    assign bus.new_high   = new_high_q;
    assign bus.score_inc  = score_inc_q;
    assign bus.playing    = playing_q;

endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker: directed rounds against a cycle model via a scoreboard queue, plus a 4-bit saturation instance.
module tb_score_tracker;
    import score_tracker_pkg::*;

    localparam int BX = BIRD_STARTING_DISTANCE;

    typedef struct {int score; int high; int nh; int inc; int play;} exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    score_tracker_if #(.NUM_PIPES(3), .POS_W(10), .SCORE_W(10)) ifc ();
    score_tracker_if #(.NUM_PIPES(1), .POS_W(10), .SCORE_W(4))  ifs ();

    score_tracker #(.NUM_PIPES(3), .POS_W(10), .SCORE_W(10)) dut (
        .clk(clk), .reset(rst_n), .bus(ifc.slave));
    score_tracker #(.NUM_PIPES(1), .POS_W(10), .SCORE_W(4)) dut_sat (
        .clk(clk), .reset(rst_n), .bus(ifs.slave));

    exp_t sb[$];
    int   vectors = 0, errs = 0, pulses = 0;
    bit   v[3];
    int   r[3];
    int   m_state, m_score, m_high, m_nh, m_inc;
    bit   m_arm[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_high = 0; m_nh = 0; m_inc = 0;
        for (int i = 0; i < 3; i++) m_arm[i] = 1'b0;
    endtask

    task automatic cyc(input bit st, input bit go);
        int   n;
        bit   x;
        exp_t e;
        ifc.start     = st;
        ifc.game_over = go;
        for (int i = 0; i < 3; i++) begin
            ifc.obs_valid[i]          = v[i];
            ifc.obs_right[i*10 +: 10] = 10'(r[i]);
        end
        n = 0;
        for (int i = 0; i < 3; i++) begin
            x = m_arm[i] && v[i] && r[i] < BX;
            if (x) n++;
            if (st && m_state != 1) m_arm[i] = v[i] && r[i] >= BX;
            else if (v[i] && r[i] >= BX) m_arm[i] = 1'b1;
            else if (x) m_arm[i] = 1'b0;
        end
        m_inc = 0;
        if (m_state != 1) begin
            if (st) begin m_state = 1; m_score = 0; m_nh = 0; end
        end else if (go) begin
            m_state = 2;
            if (m_score > m_high) begin m_high = m_score; m_nh = 1; end
        end else if (n > 0) begin
            int ns;
            ns = m_score + n > 1023 ? 1023 : m_score + n;
            m_inc = (ns != m_score) ? 1 : 0;
            m_score = ns;
        end
        e = '{m_score, m_high, m_nh, m_inc, (m_state == 1) ? 1 : 0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("score", ifc.score, e.score);
        chk("high_score", ifc.high_score, e.high);
        chk("new_high", ifc.new_high, e.nh);
        chk("score_inc", ifc.score_inc, e.inc);
        chk("playing", ifc.playing, e.play);
        pulses += int'(ifc.score_inc);
        ifc.start = 1'b0;
        ifc.game_over = 1'b0;
    endtask

    task automatic pass(input int ch);
        v[ch] = 1'b1; r[ch] = BX + 1; cyc(0, 0);
        r[ch] = BX - 1; cyc(0, 0);
    endtask

    initial begin
        ifc.start = 0; ifc.game_over = 0; ifc.obs_valid = '0; ifc.obs_right = '0;
        ifs.start = 0; ifs.game_over = 0; ifs.obs_valid = '0; ifs.obs_right = '0;
        for (int i = 0; i < 3; i++) begin v[i] = 0; r[i] = 0; end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_score", ifc.score, 0);
        chk("rst_playing", ifc.playing, 0);
        chk("rst_sat_score", ifs.score, 0);
        rst_n = 1'b1;
        // crossings before any start are ignored
        pass(0);
        chk("idle_no_point", ifc.score, 0);
        // round 1: single pass with a long hold left of the bird
        r[0] = 200; v[0] = 1; cyc(1, 0);
        pulses = 0;
        for (int p = 200; p >= 150; p -= 5) begin r[0] = p; cyc(0, 0); end
        repeat (20) cyc(0, 0);
        chk("single_score", ifc.score, 1);
        chk("single_pulses", pulses, 1);
        r[0] = 639; cyc(0, 0);
        for (int p = 630; p >= 150; p -= 10) begin r[0] = p; cyc(0, 0); end
        chk("respawn_score", ifc.score, 2);
        for (int i = 0; i < 3; i++) begin v[i] = 1; r[i] = BX + 1; end
        cyc(0, 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) r[i] = BX - 1;
        cyc(0, 0);
        chk("simul_score", ifc.score, 5);
        chk("simul_inc", ifc.score_inc, 1);
        cyc(0, 0);
        chk("simul_pulses", pulses, 1);
        cyc(1, 0);
        chk("start_ignored", ifc.score, 5);
        cyc(0, 1);
        chk("r1_high", ifc.high_score, 5);
        chk("r1_new_high", ifc.new_high, 1);
        cyc(0, 1);
        chk("over_go_ignored", ifc.playing, 0);
        // round 2: pipe already left at start, invalid channel, then 3 points
        r[0] = 100; v[0] = 1; r[1] = BX + 1; v[1] = 1; v[2] = 0;
        cyc(1, 0);
        repeat (3) cyc(0, 0);
        v[1] = 0; r[1] = BX - 1; cyc(0, 0); cyc(0, 0);
        chk("left_or_invalid_no_point", ifc.score, 0);
        r[1] = 639; v[1] = 1; cyc(0, 0);
        repeat (3) pass(2);
        cyc(0, 1);
        chk("r2_high", ifc.high_score, 5);
        chk("r2_new_high", ifc.new_high, 0);
        // round 3: 7 points, then a crossing on the game_over edge
        cyc(1, 0);
        repeat (7) pass(2);
        r[0] = BX + 1; cyc(0, 0);
        r[0] = BX - 1; cyc(0, 1);
        chk("go_cross_score", ifc.score, 7);
        chk("r3_high", ifc.high_score, 7);
        chk("r3_new_high", ifc.new_high, 1);
        // round 4 sets high 9, round 5 reaches 4 and is reset mid-cycle
        cyc(1, 0);
        repeat (9) pass(2);
        cyc(0, 1);
        cyc(1, 0);
        repeat (4) pass(2);
        chk("pre_rst_score", ifc.score, 4);
        chk("pre_rst_high", ifc.high_score, 9);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_score", ifc.score, 0);
        chk("arst_high", ifc.high_score, 0);
        chk("arst_new_high", ifc.new_high, 0);
        chk("arst_inc", ifc.score_inc, 0);
        chk("arst_playing", ifc.playing, 0);
        #2 rst_n = 1'b1;
        pass(1);
        chk("post_rst_no_point", ifc.score, 0);
        // saturation on the 4-bit instance
        ifs.obs_valid = 1'b1; ifs.obs_right = 10'd200; ifs.start = 1'b1;
        @(posedge clk); #1;
        ifs.start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            ifs.obs_right = 10'(BX + 1);
            @(posedge clk); #1;
            ifs.obs_right = 10'(BX - 1);
            @(posedge clk); #1;
            chk("sat_score", ifs.score, k > 15 ? 15 : k);
            chk("sat_inc", ifs.score_inc, k <= 15 ? 1 : 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
